systolic_feed_ctrl: RTL

Sequencer for the bank of DEPTH transpose FIFOs that feed the systolic multiply array. On `start` it loads one matrix row per FIFO from the operand buffer, then drives the per-FIFO shift enables with a one-cycle diagonal skew so row i enters the array i cycles after row 0. It then waits out the array pipeline and pulses `done`. It owns every `WrEn`/`en` of the FIFO bank and the array accumulator clear.

---
 rtl/systolic_feed_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/systolic_feed_ctrl.sv
// systolic_feed_ctrl: sequences the transpose-FIFO bank that feeds the
// systolic array. A run loads one operand row per FIFO, shifts the FIFOs
// out with a one-cycle diagonal skew, waits for the array pipeline to
// drain, and then pulses done. Every output is a flop. Its next value is
// decoded from the next state and count, so each output lines up with
// the state and counter it describes.
module systolic_feed_ctrl #(
    parameter int DEPTH = 8,
    parameter int DRAIN = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     mem_rd_en,
    output logic [$clog2(DEPTH)-1:0] mem_addr,
    output logic [DEPTH-1:0]         wr_en,
    output logic [DEPTH-1:0]         shift_en,
    output logic [DEPTH-1:0]         feed_valid,
    output logic                     acc_clr,
    output logic                     busy,
    output logic                     done
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CMAX = (2 * DEPTH > DRAIN) ? 2 * DEPTH : DRAIN;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] LOAD_LAST  = CW'(DEPTH);
    localparam logic [CW-1:0] FEED_LAST  = CW'(2 * DEPTH - 2);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t          state_r;
    state_t          state_n;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   cnt_n;

    logic            rd_d;
    logic [AW-1:0]   addr_d;
    logic [DEPTH-1:0] wr_d;
    logic [DEPTH-1:0] sh_d;
    logic            acc_d;
    logic            busy_d;
    logic            done_d;

    // State and phase counter registers; reset aborts any run in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
        end
    end

    // Next-state logic. The counter restarts at zero on every state entry.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r + CNT_ONE;
        case (state_r)
            ST_IDLE: begin
                cnt_n = CNT_ZERO;
                if (start) begin
                    state_n = ST_LOAD;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (cnt_r == LOAD_LAST) begin
                    state_n = ST_FEED;
                    cnt_n   = CNT_ZERO;
                end else begin
                    state_n = ST_LOAD;
                end
            end
            ST_FEED: begin
                if (cnt_r == FEED_LAST) begin
                    state_n = ST_DRAIN;
                    cnt_n   = CNT_ZERO;
                end else begin
                    state_n = ST_FEED;
                end
            end
            ST_DRAIN: begin
                if (cnt_r == DRAIN_LAST) begin
                    state_n = ST_DONE;
                    cnt_n   = CNT_ZERO;
                end else begin
                    state_n = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
                cnt_n   = CNT_ZERO;
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = CNT_ZERO;
            end
        endcase
    end

    // Output decode from next state/count. The flops below then present
    // each value in the same cycle as the state it belongs to.
    always_comb begin
        rd_d   = 1'b0;
        addr_d = {AW{1'b0}};
        wr_d   = {DEPTH{1'b0}};
        sh_d   = {DEPTH{1'b0}};
        acc_d  = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_n)
            ST_LOAD: begin
                busy_d = 1'b1;
                acc_d  = (cnt_n == CNT_ZERO);
                if (cnt_n < LOAD_LAST) begin
                    rd_d   = 1'b1;
                    addr_d = cnt_n[AW-1:0];
                end else begin
                    rd_d   = 1'b0;
                    addr_d = {AW{1'b0}};
                end
                // Row k read data returns one cycle after its read, at cnt = k+1.
                for (int k = 0; k < DEPTH; k++) begin
                    wr_d[k] = (cnt_n == CW'(k + 1));
                end
            end
            ST_FEED: begin
                busy_d = 1'b1;
                // FIFO i shifts during the DEPTH counts starting at cnt = i.
                for (int i = 0; i < DEPTH; i++) begin
                    sh_d[i] = (cnt_n >= CW'(i)) && (cnt_n < CW'(i + DEPTH));
                end
            end
            ST_DRAIN: begin
                busy_d = 1'b1;
            end
            ST_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Output registers; all clear at once when reset is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rd_en  <= 1'b0;
            mem_addr   <= {AW{1'b0}};
            wr_en      <= {DEPTH{1'b0}};
            shift_en   <= {DEPTH{1'b0}};
            feed_valid <= {DEPTH{1'b0}};
            acc_clr    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            mem_rd_en  <= rd_d;
            mem_addr   <= addr_d;
            wr_en      <= wr_d;
            shift_en   <= sh_d;
            feed_valid <= sh_d;
            acc_clr    <= acc_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

endmodule
